// File: rtl/module_instr_fetch_pkg.sv
// Shared fetch/decode definitions: default geometry, opcode encodings and
// instruction field positions.
package module_instr_fetch_pkg;

    localparam int unsigned IF_ADDR_W   = 8;
    localparam int unsigned IF_INSTR_W  = 16;
    localparam int unsigned IF_OPCODE_W = 3;
    localparam int unsigned IF_DEPTH    = 4;
    localparam int unsigned IF_RESET_PC = 0;

    localparam int unsigned OPCODE_MSB = IF_INSTR_W - 1;
    localparam int unsigned OPCODE_LSB = IF_INSTR_W - IF_OPCODE_W;

    typedef enum logic [IF_OPCODE_W-1:0] {
        OP_ADD  = 3'b000,
        OP_MOVI = 3'b001
    } opcode_e;

endpackage

// File: rtl/module_prefetch_fifo.sv
// Synchronous prefetch FIFO; head word is read straight from registered storage.
module module_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_ONE;
            if (do_pop)  rptr_d = rptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/module_instr_fetch.sv
// Fetch stage: PC, credit-based reads into the prefetch queue, redirect flush,
// and valid/ready delivery of {instr, opcode, pc} to the decoder.
module module_instr_fetch
    import module_instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = IF_ADDR_W,
    parameter int unsigned INSTR_W  = IF_INSTR_W,
    parameter int unsigned OPCODE   = IF_OPCODE_W,
    parameter int unsigned DEPTH    = IF_DEPTH,
    parameter int unsigned RESET_PC = IF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [OPCODE-1:0]  opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_push, fifo_pop;
    logic [CNT_W:0]     credit_used;
    logic               issue;

    // Queue slots already spoken for: stored words plus the response on its way.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue       = !rst && !redirect_en && !fifo_full
                         && (credit_used < (CNT_W+1)'(DEPTH));

    // A response arriving during a redirect belongs to the abandoned stream.
    assign fifo_push = inflight_q && !redirect_en && !rst;
    assign fifo_pop  = instr_valid && instr_ready && !redirect_en;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_en) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    module_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_en),
        .din   ({imem_rdata, inflight_pc_q}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign imem_rd_en  = issue;
    assign imem_addr   = pc_q;
    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? fifo_dout[ENTRY_W-1 -: INSTR_W] : '0;
    assign instr_pc    = instr_valid ? fifo_dout[ADDR_W-1:0] : '0;
    assign opcode      = instr[INSTR_W-1 -: OPCODE];

endmodule

// File: tb/tb_module_instr_fetch.sv
// Bench for module_instr_fetch: directed phases feed an expected-delivery queue
// that a negedge monitor pops on every decoder transfer.
module tb_module_instr_fetch;
    import module_instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [7:0]  instr_pc;
    logic        redirect_en;
    logic [7:0]  redirect_pc;

    always #5 clk = ~clk;

    module_instr_fetch #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .OPCODE   (3),
        .DEPTH    (4),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc)
    );

    int mem_mode = 0;
    int n_vec = 0;
    int n_err = 0;
    int sb_delivered = 0;
    logic [23:0] sb_q[$];

    // Mode 0: 16'h1000+addr (opcode ADD); mode 1: opcode = addr[2:0], distinct data.
    function automatic logic [15:0] mem_word(input int mode, input logic [7:0] a);
        if (mode == 0) return 16'h1000 + {8'h00, a};
        return {a[2:0], 5'b10101, a};
    endfunction

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(mem_mode, imem_addr);
        else            imem_rdata <= 16'hBAD0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [7:0] start);
        sb_q.delete();
        sb_delivered = 0;
        for (int k = 0; k < 64; k++) begin
            logic [7:0] a;
            a = start + 8'(k);
            sb_q.push_back({a, mem_word(mem_mode, a)});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_deliv(input string name, input int n, input int budget);
        for (int i = 0; i < budget && sb_delivered < n; i++) @(posedge clk);
        chk(name, sb_delivered, n);
        #1;
    endtask

    // Monitor: scoreboard pops on transfers, plus hold-while-stalled checks.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_instr;
    logic [7:0]  prev_pc;
    logic [23:0] exp_e;

    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", instr, prev_instr);
            chk("stall_pc", instr_pc, prev_pc);
        end
        prev_stall = instr_valid && !instr_ready && !redirect_en && !rst;
        prev_instr = instr;
        prev_pc    = instr_pc;
        if (instr_valid && instr_ready && !redirect_en && !rst) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                exp_e = sb_q.pop_front();
                chk("deliv_pc", instr_pc, exp_e[23:16]);
                chk("deliv_instr", instr, exp_e[15:0]);
                chk("deliv_opcode", opcode, exp_e[15:13]);
                sb_delivered++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        logic [7:0] rpc;

        rst = 1'b1; instr_ready = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        mem_mode = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_pc", instr_pc, 0);

        // Streaming from reset release (cycle 0)
        @(posedge clk); #1;
        rst = 1'b0; instr_ready = 1'b1;
        sb_restart(8'h00);
        @(negedge clk);
        chk("c0_rd_en", imem_rd_en, 1);
        chk("c0_addr", imem_addr, 8'h00);
        @(negedge clk);
        chk("c1_valid", instr_valid, 0);
        chk("c1_rd_en", imem_rd_en, 1);
        chk("c1_addr", imem_addr, 8'h01);
        @(negedge clk);
        chk("c2_valid", instr_valid, 1);
        chk("c2_pc", instr_pc, 8'h00);
        chk("c2_opcode", opcode, OP_ADD);
        repeat (10) @(posedge clk);
        chk("stream_rate", sb_delivered, 10);
        #1;

        // Backpressure from reset: only DEPTH reads, head held at pc 0
        rst = 1'b1; instr_ready = 1'b0;
        tick();
        rst = 1'b0;
        sb_restart(8'h00);
        rd_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_rd_en) rd_cnt++;
        end
        chk("bp_reads", rd_cnt, 4);
        chk("bp_rd_idle", imem_rd_en, 0);
        chk("bp_head_valid", instr_valid, 1);
        chk("bp_head_pc", instr_pc, 8'h00);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        wait_deliv("bp_drain", 6, 30);

        // Redirect with 3 queued and 1 in flight
        rst = 1'b1; instr_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_redir_rd_en", imem_rd_en, 1);
        chk("pre_redir_addr", imem_addr, 8'h03);
        @(posedge clk); #1;
        redirect_en = 1'b1; redirect_pc = 8'h40; instr_ready = 1'b1;
        mem_mode = 1;
        sb_restart(8'h40);
        @(negedge clk);
        chk("redir_no_rd", imem_rd_en, 0);
        @(posedge clk); #1;
        redirect_en = 1'b0;
        @(negedge clk);
        chk("post_redir_valid", instr_valid, 0);
        chk("post_redir_rd_en", imem_rd_en, 1);
        chk("post_redir_addr", imem_addr, 8'h40);
        @(posedge clk); #1;
        wait_deliv("redir_stream", 5, 20);

        // PC wrap FE, FF, 00, 01
        redirect_en = 1'b1; redirect_pc = 8'hFE;
        sb_restart(8'hFE);
        tick();
        redirect_en = 1'b0;
        wait_deliv("wrap_stream", 4, 20);

        // Reset mid-stream: 2 queued, 1 read in flight
        rst = 1'b1; instr_ready = 1'b0;
        mem_mode = 0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("mid_pre_valid", instr_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_mode = 1;
        tick();
        rst = 1'b0; instr_ready = 1'b1;
        sb_restart(8'h00);
        @(negedge clk);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_rd_en", imem_rd_en, 1);
        chk("mid_rst_addr", imem_addr, 8'h00);
        @(posedge clk); #1;
        wait_deliv("mid_rst_stream", 5, 20);

        // Random ready with periodic (sometimes back-to-back) redirects
        for (int cyc = 0; cyc < 400; cyc++) begin
            redirect_en = 1'b0;
            instr_ready = ($urandom_range(0, 3) != 0);
            if ((cyc % 41) == 7 || (cyc % 97) == 20 || (cyc % 97) == 21) begin
                rpc = 8'($urandom_range(0, 255));
                redirect_en = 1'b1;
                redirect_pc = rpc;
                sb_restart(rpc);
            end
            tick();
        end
        redirect_en = 1'b0;
        instr_ready = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
